axi4_lite_slv_q: RTL and testbench

AXI4-Lite slave front end that converts write and read transactions into push/pull operations on external request/response FIFOs, feeding the SPI transaction engine. Successor to the first-generation FIFO bridge:
- parametrised data/address width and outstanding-transaction limit;
- joins AW and W into one write-request word;
- fully registered VALID/READY handshakes with one-entry holding registers;
- optional local SLVERR for misaligned addresses.

---
 rtl/axi4_lite_slv_q.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_lite_slv_q.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slv_q.sv
// AXI4-Lite slave front end: AW/W/AR holding registers push request FIFOs, B/R are loaded from response FIFOs.
// Optional: define AXI_SLV_ALIGN_CHECK_EN to answer misaligned addresses locally with SLVERR.
module axi4_lite_slv_q #(
   parameter int g_axi_data_width  = 32,
   parameter int g_axi_addr_width  = 28,
   parameter int g_max_outstanding = 4
) (
   input  logic                                                      aclk_i,
   input  logic                                                      areset_i,
   input  logic                                                      awvalid_i,
   output logic                                                      awready_o,
   input  logic [g_axi_addr_width-1:0]                               awaddr_i,
   input  logic [2:0]                                                awprot_i,
   input  logic                                                      wvalid_i,
   output logic                                                      wready_o,
   input  logic [g_axi_data_width-1:0]                               wdata_i,
   input  logic [g_axi_data_width/8-1:0]                             wstrb_i,
   output logic                                                      bvalid_o,
   input  logic                                                      bready_i,
   output logic [1:0]                                                bresp_o,
   input  logic                                                      arvalid_i,
   output logic                                                      arready_o,
   input  logic [g_axi_addr_width-1:0]                               araddr_i,
   input  logic [2:0]                                                arprot_i,
   output logic                                                      rvalid_o,
   input  logic                                                      rready_i,
   output logic [g_axi_data_width-1:0]                               rdata_o,
   output logic [1:0]                                                rresp_o,
   input  logic                                                      wr_req_full_i,
   output logic                                                      wr_req_push_o,
   output logic [g_axi_addr_width+3+g_axi_data_width+g_axi_data_width/8-1:0] wr_req_data_o,
   input  logic                                                      wr_resp_empty_i,
   input  logic [1:0]                                                wr_resp_data_i,
   output logic                                                      wr_resp_pull_o,
   input  logic                                                      rd_req_full_i,
   output logic                                                      rd_req_push_o,
   output logic [g_axi_addr_width+2:0]                               rd_req_data_o,
   input  logic                                                      rd_resp_empty_i,
   input  logic [g_axi_data_width+1:0]                               rd_resp_data_i,
   output logic                                                      rd_resp_pull_o,
   output logic [1:0]                                                dbg_state_o
);

   localparam int         c_strb_w = g_axi_data_width / 8;
   localparam logic [3:0] c_max    = 4'(g_max_outstanding);
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_RESP   = 1'b1;

   logic                        aw_held_q, aw_held_d;
   logic [g_axi_addr_width-1:0] aw_addr_q;
   logic [2:0]                  aw_prot_q;
   logic                        w_held_q, w_held_d;
   logic [g_axi_data_width-1:0] w_data_q;
   logic [c_strb_w-1:0]         w_strb_q;
   logic                        ar_held_q, ar_held_d;
   logic [g_axi_addr_width-1:0] ar_addr_q;
   logic [2:0]                  ar_prot_q;

   logic aw_hs, w_hs, ar_hs;
   logic wr_misalign, rd_misalign;
   logic wr_push, rd_push, wr_local, rd_local, wr_pull, rd_pull, b_hs, r_hs;

   logic [0:0]                  wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic [3:0]                  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic                        wr_local_q, wr_local_d, rd_local_q, rd_local_d;
   logic [1:0]                  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [g_axi_data_width-1:0] rdata_q, rdata_d;

`ifdef AXI_SLV_ALIGN_CHECK_EN
   localparam int c_lsb = $clog2(c_strb_w);
   assign wr_misalign = |aw_addr_q[c_lsb-1:0];
   assign rd_misalign = |ar_addr_q[c_lsb-1:0];
`else
   assign wr_misalign = 1'b0;
   assign rd_misalign = 1'b0;
`endif

   // Valid/ready: a transfer happens on a rising edge where both are high; every
   // ready comes straight from a register and every valid holds its payload until taken.
   assign awready_o = ~aw_held_q;
   assign wready_o  = ~w_held_q;
   assign arready_o = ~ar_held_q;
   assign aw_hs     = awvalid_i & ~aw_held_q;
   assign w_hs      = wvalid_i & ~w_held_q;
   assign ar_hs     = arvalid_i & ~ar_held_q;

   assign wr_push  = aw_held_q & w_held_q & ~wr_misalign & ~wr_req_full_i & (wr_cnt_q < c_max);
   assign rd_push  = ar_held_q & ~rd_misalign & ~rd_req_full_i & (rd_cnt_q < c_max);
   // Local errors wait for an empty pipe so they cannot overtake FIFO responses.
   assign wr_local = aw_held_q & w_held_q & wr_misalign & (wr_state_q == S_IDLE) & (wr_cnt_q == 4'd0);
   assign rd_local = ar_held_q & rd_misalign & (rd_state_q == S_IDLE) & (rd_cnt_q == 4'd0);
   assign wr_pull  = (wr_state_q == S_IDLE) & ~wr_resp_empty_i & (wr_cnt_q != 4'd0);
   assign rd_pull  = (rd_state_q == S_IDLE) & ~rd_resp_empty_i & (rd_cnt_q != 4'd0);
   assign b_hs     = (wr_state_q == S_RESP) & bready_i;
   assign r_hs     = (rd_state_q == S_RESP) & rready_i;

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      ar_held_d = ar_held_q;
      if (wr_push | wr_local) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end else begin
         if (aw_hs) aw_held_d = 1'b1;
         if (w_hs)  w_held_d  = 1'b1;
      end
      if (rd_push | rd_local) ar_held_d = 1'b0;
      else if (ar_hs)         ar_held_d = 1'b1;
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wr_local_d = wr_local_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         S_IDLE: begin
            if (wr_pull) begin
               wr_state_d = S_RESP;
               bresp_d    = wr_resp_data_i;
               wr_local_d = 1'b0;
            end else if (wr_local) begin
               wr_state_d = S_RESP;
               bresp_d    = 2'b10;
               wr_local_d = 1'b1;
            end
         end
         default: if (bready_i) wr_state_d = S_IDLE;
      endcase
      wr_cnt_d = wr_cnt_q + {3'b000, wr_push} - {3'b000, b_hs & ~wr_local_q};
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_local_d = rd_local_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         S_IDLE: begin
            if (rd_pull) begin
               rd_state_d = S_RESP;
               rdata_d    = rd_resp_data_i[g_axi_data_width+1:2];
               rresp_d    = rd_resp_data_i[1:0];
               rd_local_d = 1'b0;
            end else if (rd_local) begin
               rd_state_d = S_RESP;
               rdata_d    = '0;
               rresp_d    = 2'b10;
               rd_local_d = 1'b1;
            end
         end
         default: if (rready_i) rd_state_d = S_IDLE;
      endcase
      rd_cnt_d = rd_cnt_q + {3'b000, rd_push} - {3'b000, r_hs & ~rd_local_q};
   end

   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         aw_prot_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         ar_held_q  <= 1'b0;
         ar_addr_q  <= '0;
         ar_prot_q  <= '0;
         wr_state_q <= S_IDLE;
         rd_state_q <= S_IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         wr_local_q <= 1'b0;
         rd_local_q <= 1'b0;
         bresp_q    <= '0;
         rresp_q    <= '0;
         rdata_q    <= '0;
      end else begin
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         ar_held_q  <= ar_held_d;
         if (aw_hs) begin
            aw_addr_q <= awaddr_i;
            aw_prot_q <= awprot_i;
         end
         if (w_hs) begin
            w_data_q <= wdata_i;
            w_strb_q <= wstrb_i;
         end
         if (ar_hs) begin
            ar_addr_q <= araddr_i;
            ar_prot_q <= arprot_i;
         end
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_local_q <= wr_local_d;
         rd_local_q <= rd_local_d;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   assign wr_req_push_o  = wr_push;
   assign wr_req_data_o  = {aw_addr_q, aw_prot_q, w_data_q, w_strb_q};
   assign rd_req_push_o  = rd_push;
   assign rd_req_data_o  = {ar_addr_q, ar_prot_q};
   assign wr_resp_pull_o = wr_pull;
   assign rd_resp_pull_o = rd_pull;
   assign bvalid_o       = (wr_state_q == S_RESP);
   assign bresp_o        = bresp_q;
   assign rvalid_o       = (rd_state_q == S_RESP);
   assign rdata_o        = rdata_q;
   assign rresp_o        = rresp_q;
   assign dbg_state_o    = {wr_state_q, rd_state_q};

endmodule

// File: tb/tb_axi4_lite_slv_q.sv
// Bench for axi4_lite_slv_q: table-driven write/read vectors, FIFO models and a scoreboard,
// plus hand sequences for latency, ordering, outstanding limit, back-pressure, reset and alignment.
`timescale 1ns/1ps
module tb_axi4_lite_slv_q;
   localparam int D   = 32;
   localparam int A   = 28;
   localparam int S   = 4;
   localparam int WRW = A + 3 + D + S;
   localparam int RDW = A + 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           areset = 1'b1;
   logic           awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
   logic [A-1:0]   awaddr = '0, araddr = '0;
   logic [2:0]     awprot = '0, arprot = '0;
   logic [D-1:0]   wdata = '0;
   logic [S-1:0]   wstrb = '0;
   logic           wr_req_full = 0, rd_req_full = 0;
   logic           awready, wready, arready, bvalid, rvalid;
   logic [1:0]     bresp, rresp, dbg_state;
   logic [D-1:0]   rdata;
   logic           wr_req_push, rd_req_push, wr_resp_pull, rd_resp_pull;
   logic [WRW-1:0] wr_req_data;
   logic [RDW-1:0] rd_req_data;
   logic           wr_resp_empty, rd_resp_empty;
   logic [1:0]     wr_resp_data;
   logic [D+1:0]   rd_resp_data;

   axi4_lite_slv_q dut (
      .aclk_i(clk), .areset_i(areset),
      .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
      .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
      .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
      .wr_req_full_i(wr_req_full), .wr_req_push_o(wr_req_push), .wr_req_data_o(wr_req_data),
      .wr_resp_empty_i(wr_resp_empty), .wr_resp_data_i(wr_resp_data), .wr_resp_pull_o(wr_resp_pull),
      .rd_req_full_i(rd_req_full), .rd_req_push_o(rd_req_push), .rd_req_data_o(rd_req_data),
      .rd_resp_empty_i(rd_resp_empty), .rd_resp_data_i(rd_resp_data), .rd_resp_pull_o(rd_resp_pull),
      .dbg_state_o(dbg_state)
   );

   int n_tests = 0, n_fail = 0;
   int n_wr_push = 0, n_rd_push = 0, n_rd_pull = 0;
   logic [WRW-1:0] exp_wr_q[$];
   logic [RDW-1:0] exp_rd_q[$];
   logic [1:0]     exp_b_q[$];
   logic [D+1:0]   exp_r_q[$];

   // Response FIFO models, first-word-fall-through.
   logic [1:0]   wr_mem [0:15];
   logic [D+1:0] rd_mem [0:15];
   logic [3:0]   wr_wp = '0, wr_rp = '0, rd_wp = '0, rd_rp = '0;
   assign wr_resp_empty = (wr_wp == wr_rp);
   assign rd_resp_empty = (rd_wp == rd_rp);
   assign wr_resp_data  = wr_mem[wr_rp];
   assign rd_resp_data  = rd_mem[rd_rp];
   always @(posedge clk) begin
      if (wr_resp_pull) wr_rp <= wr_rp + 4'd1;
      if (rd_resp_pull) rd_rp <= rd_rp + 4'd1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event seen with nothing expected (or bound expired)", name);
   endtask

   // Scoreboard: pops expected entries as the DUT produces pushes and responses.
   always @(negedge clk) begin
      if (!areset) begin
         if (wr_req_push) begin
            n_wr_push++;
            if (exp_wr_q.size() == 0) fail_now("wr_req_unexpected");
            else check("wr_req_data", 128'(wr_req_data), 128'(exp_wr_q.pop_front()));
         end
         if (rd_req_push) begin
            n_rd_push++;
            if (exp_rd_q.size() == 0) fail_now("rd_req_unexpected");
            else check("rd_req_data", 128'(rd_req_data), 128'(exp_rd_q.pop_front()));
         end
         if (bvalid && bready) begin
            if (exp_b_q.size() == 0) fail_now("b_unexpected");
            else check("bresp", 128'(bresp), 128'(exp_b_q.pop_front()));
         end
         if (rvalid && rready) begin
            if (exp_r_q.size() == 0) fail_now("r_unexpected");
            else check("rdata_rresp", 128'({rdata, rresp}), 128'(exp_r_q.pop_front()));
         end
         if (rd_resp_pull) n_rd_pull++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_aw(input logic [A-1:0] addr, input logic [2:0] prot, input int dly);
      bit ok = 0;
      step(dly);
      awaddr = addr; awprot = prot; awvalid = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (awready) begin ok = 1; break; end
      end
      step(1);
      awvalid = 0;
      if (!ok) fail_now("aw_timeout");
   endtask

   task automatic send_w(input logic [D-1:0] data, input logic [S-1:0] strb, input int dly);
      bit ok = 0;
      step(dly);
      wdata = data; wstrb = strb; wvalid = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wready) begin ok = 1; break; end
      end
      step(1);
      wvalid = 0;
      if (!ok) fail_now("w_timeout");
   endtask

   task automatic send_ar(input logic [A-1:0] addr, input logic [2:0] prot);
      bit ok = 0;
      araddr = addr; arprot = prot; arvalid = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (arready) begin ok = 1; break; end
      end
      step(1);
      arvalid = 0;
      if (!ok) fail_now("ar_timeout");
   endtask

   task automatic load_wr_resp(input logic [1:0] r);
      wr_mem[wr_wp] = r;
      wr_wp = wr_wp + 4'd1;
   endtask

   task automatic load_rd_resp(input logic [D+1:0] r);
      rd_mem[rd_wp] = r;
      rd_wp = rd_wp + 4'd1;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_b_q.size() == 0 &&
             exp_r_q.size() == 0 && !bvalid && !rvalid) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         fail_now({name, "_idle_timeout"});
         exp_wr_q.delete(); exp_rd_q.delete(); exp_b_q.delete(); exp_r_q.delete();
      end
      step(1);
   endtask

   typedef struct {
      logic [A-1:0]   addr;
      logic [2:0]     prot;
      logic [D-1:0]   data;
      logic [S-1:0]   strb;
      int             w_lead;    // >0: W leads AW by that many cycles, <0: AW leads
      logic [1:0]     resp;
      logic [WRW-1:0] exp_req;
      logic [1:0]     exp_bresp;
   } wr_vec_t;

   typedef struct {
      logic [A-1:0]   addr;
      logic [2:0]     prot;
      logic [D-1:0]   data;
      logic [1:0]     resp;
      logic [RDW-1:0] exp_req;
      logic [D+1:0]   exp_r;
   } rd_vec_t;

   wr_vec_t wv[4];
   rd_vec_t rv[3];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation bound expired");
      $fatal(1, "global timeout");
   end

   initial begin
      int n0;
      wv[0] = '{28'h0000100, 3'b010, 32'h01234567, 4'h3,  0, 2'b00, '0, '0};
      wv[1] = '{28'h0ABCDE0, 3'b001, 32'hCAFEF00D, 4'h8,  1, 2'b10, '0, '0};
      wv[2] = '{28'h0000004, 3'b111, 32'hFFFFFFFF, 4'hF, -2, 2'b11, '0, '0};
      wv[3] = '{28'hFFFFFFC, 3'b000, 32'h00000000, 4'h0,  0, 2'b01, '0, '0};
      foreach (wv[i]) begin
         wv[i].exp_req   = {wv[i].addr, wv[i].prot, wv[i].data, wv[i].strb};
         wv[i].exp_bresp = wv[i].resp;
      end
      rv[0] = '{28'h0000020, 3'b000, 32'h12345678, 2'b00, '0, '0};
      rv[1] = '{28'hFFFFFF0, 3'b101, 32'hA5A5A5A5, 2'b10, '0, '0};
      rv[2] = '{28'h0001000, 3'b010, 32'h00000000, 2'b01, '0, '0};
      foreach (rv[i]) begin
         rv[i].exp_req = {rv[i].addr, rv[i].prot};
         rv[i].exp_r   = {rv[i].data, rv[i].resp};
      end

      step(3);
      areset = 0;
      @(negedge clk);
      check("rst_awready", 128'(awready), 128'(1));
      check("rst_wready", 128'(wready), 128'(1));
      check("rst_arready", 128'(arready), 128'(1));
      check("rst_valids", 128'({bvalid, rvalid}), 128'(0));
      check("rst_pushpull", 128'({wr_req_push, rd_req_push, wr_resp_pull, rd_resp_pull}), 128'(0));
      check("rst_payload", 128'({bresp, rdata, rresp, wr_req_data, rd_req_data}), 128'(0));
      step(1);

      // Single write with AW and W in the same cycle: latency through push and response.
      load_wr_resp(2'b00);
      exp_b_q.push_back(2'b00);
      exp_wr_q.push_back({28'h0000010, 3'b000, 32'hDEADBEEF, 4'hF});
      awaddr = 28'h0000010; awprot = 3'b000; awvalid = 1;
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
      @(negedge clk);
      check("push_before_accept", 128'(wr_req_push), 128'(0));
      step(1);
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      check("push_latency", 128'(wr_req_push), 128'(1));
      check("awready_after_accept", 128'(awready), 128'(0));
      step(1);
      @(negedge clk);
      check("awready_after_push", 128'(awready), 128'(1));
      check("wr_pull", 128'({wr_resp_pull, bvalid}), 128'(2'b10));
      step(1);
      @(negedge clk);
      check("bvalid_latency", 128'({bvalid, bresp}), 128'(3'b100));
      wait_idle("first_write");

      foreach (wv[i]) begin
         load_wr_resp(wv[i].resp);
         exp_b_q.push_back(wv[i].exp_bresp);
         exp_wr_q.push_back(wv[i].exp_req);
         fork
            send_aw(wv[i].addr, wv[i].prot, (wv[i].w_lead > 0) ? wv[i].w_lead : 0);
            send_w(wv[i].data, wv[i].strb, (wv[i].w_lead < 0) ? -wv[i].w_lead : 0);
         join
         wait_idle("wr_vec");
      end

      foreach (rv[i]) begin
         load_rd_resp(rv[i].exp_r);
         exp_r_q.push_back(rv[i].exp_r);
         exp_rd_q.push_back(rv[i].exp_req);
         send_ar(rv[i].addr, rv[i].prot);
         wait_idle("rd_vec");
      end

      // W two cycles ahead of AW: single push, W stays blocked meanwhile.
      n0 = n_wr_push;
      load_wr_resp(2'b00);
      exp_b_q.push_back(2'b00);
      exp_wr_q.push_back({28'h0000040, 3'b000, 32'h55AA55AA, 4'hF});
      send_w(32'h55AA55AA, 4'hF, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("wready_held", 128'(wready), 128'(0));
         check("no_push_w_only", 128'(wr_req_push), 128'(0));
         step(1);
      end
      send_aw(28'h0000040, 3'b000, 0);
      wait_idle("w_first");
      check("w_first_push_count", 128'(n_wr_push - n0), 128'(1));

      // Outstanding limit of 4 reads with an empty response FIFO.
      n0 = n_rd_push;
      for (int k = 0; k < 5; k++) begin
         exp_rd_q.push_back({28'(32'h200 + 32'(k) * 4), 3'b000});
         send_ar(28'(32'h200 + 32'(k) * 4), 3'b000);
      end
      step(3);
      @(negedge clk);
      check("limit_push_count", 128'(n_rd_push - n0), 128'(4));
      check("limit_arready", 128'(arready), 128'(0));
      check("limit_no_push", 128'(rd_req_push), 128'(0));
      step(1);
      load_rd_resp({32'h11110000, 2'b00});
      exp_r_q.push_back({32'h11110000, 2'b00});
      for (int k = 0; k < 20 && (n_rd_push - n0) < 5; k++) @(negedge clk);
      check("limit_fifth_push", 128'(n_rd_push - n0), 128'(5));
      step(1);
      for (int k = 0; k < 4; k++) begin
         load_rd_resp({32'(32'h22220000 + k), 2'(k)});
         exp_r_q.push_back({32'(32'h22220000 + k), 2'(k)});
      end
      wait_idle("limit_drain");

      // Back-pressure on R: payload held, one pull only.
      rready = 0;
      n0 = n_rd_pull;
      load_rd_resp({32'h12345678, 2'b00});
      exp_r_q.push_back({32'h12345678, 2'b00});
      exp_rd_q.push_back({28'h0000030, 3'b000});
      send_ar(28'h0000030, 3'b000);
      for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("bp_rvalid", 128'(rvalid), 128'(1));
         check("bp_payload", 128'({rdata, rresp}), 128'({32'h12345678, 2'b00}));
         @(negedge clk);
      end
      check("bp_pull_count", 128'(n_rd_pull - n0), 128'(1));
      step(1);
      rready = 1;
      wait_idle("backpressure");

      // Synchronous reset with a held AW and a pending B.
      bready = 0;
      load_wr_resp(2'b01);
      exp_wr_q.push_back({28'h0000080, 3'b000, 32'h0BEEF000, 4'hF});
      fork
         send_aw(28'h0000080, 3'b000, 0);
         send_w(32'h0BEEF000, 4'hF, 0);
      join
      for (int k = 0; k < 20 && !bvalid; k++) @(negedge clk);
      step(1);
      send_aw(28'h0000090, 3'b000, 0);
      n0 = n_wr_push;
      @(negedge clk);
      check("pre_reset_state", 128'({bvalid, awready}), 128'(2'b10));
      step(1);
      areset = 1;
      step(1);
      areset = 0;
      @(negedge clk);
      check("post_reset_bvalid", 128'(bvalid), 128'(0));
      check("post_reset_awready", 128'(awready), 128'(1));
      check("post_reset_push", 128'(wr_req_push), 128'(0));
      step(1);
      bready = 1;
      step(3);
      check("post_reset_no_push", 128'(n_wr_push - n0), 128'(0));
      wait_idle("reset");

`ifdef AXI_SLV_ALIGN_CHECK_EN
      // Misaligned read behind one outstanding read: local SLVERR after it, no push.
      n0 = n_rd_push;
      exp_rd_q.push_back({28'h0000050, 3'b000});
      send_ar(28'h0000050, 3'b000);
      exp_r_q.push_back({32'h0BADF00D, 2'b00});
      exp_r_q.push_back({32'h00000000, 2'b10});
      send_ar(28'h0000002, 3'b000);
      step(3);
      @(negedge clk);
      check("align_no_push", 128'(n_rd_push - n0), 128'(1));
      check("align_wait_order", 128'(rvalid), 128'(0));
      step(1);
      load_rd_resp({32'h0BADF00D, 2'b00});
      wait_idle("align_read");
      check("align_push_total", 128'(n_rd_push - n0), 128'(1));
      n0 = n_wr_push;
      exp_b_q.push_back(2'b10);
      fork
         send_aw(28'h0000001, 3'b000, 0);
         send_w(32'h77777777, 4'hF, 0);
      join
      wait_idle("align_write");
      check("align_write_no_push", 128'(n_wr_push - n0), 128'(0));
`else
      // Misaligned addresses are forwarded unchanged.
      exp_rd_q.push_back({28'h0000002, 3'b000});
      exp_r_q.push_back({32'h0000600D, 2'b00});
      load_rd_resp({32'h0000600D, 2'b00});
      send_ar(28'h0000002, 3'b000);
      wait_idle("unaligned_read");
      load_wr_resp(2'b00);
      exp_b_q.push_back(2'b00);
      exp_wr_q.push_back({28'h0000001, 3'b000, 32'h77777777, 4'hF});
      fork
         send_aw(28'h0000001, 3'b000, 0);
         send_w(32'h77777777, 4'hF, 0);
      join
      wait_idle("unaligned_write");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
